// File: rtl/serial_pkg.sv
// Shared types for the parametrised serial transmitter: FSM states and parity modes.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    PAR     = 2'd2,
    STANDBY = 2'd3
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/sb_down_counter.sv
// Loadable down-counter with a zero flag, used to time the stand-by gap after a frame.
module sb_down_counter #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/param_serial_out.sv
// Serialises an MSG_W-bit word onto one line with optional parity and a programmable
// stand-by gap; a valid/ready handshake loads each word, state_send marks frame start.
module param_serial_out
  import serial_pkg::*;
#(
  parameter int MSG_W     = 4,
  parameter int SB_W      = 4,
  parameter int MSB_FIRST = 1,
  parameter int PARITY    = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [MSG_W-1:0] msg,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [SB_W-1:0]  SB,
  output logic             state_send,
  output logic             state_out,
  output logic             busy
);

  localparam bit HAS_PAR = (PARITY != PAR_NONE);
  localparam int L       = MSG_W + (HAS_PAR ? 1 : 0);
  localparam int CNT_W   = (L > 1) ? $clog2(L) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(MSG_W - 1);

  state_t           state;
  logic [MSG_W-1:0] shreg;
  logic [MSG_W-1:0] shreg_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic             par_q;
  logic             par_calc;
  logic             first_bit;
  logic             nxt_bit;
  logic             accept;
  logic             last_bit;
  logic             to_gap;
  logic             sb_dec;
  logic             sb_zero;

  // Shift direction: the next bit always leaves from the same end of the register.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign first_bit = msg[MSG_W-1];
      assign shreg_nxt = shreg << 1;
      assign nxt_bit   = shreg_nxt[MSG_W-1];
    end else begin : g_lsb
      assign first_bit = msg[0];
      assign shreg_nxt = shreg >> 1;
      assign nxt_bit   = shreg_nxt[0];
    end
  endgenerate

  generate
    if (PARITY == PAR_EVEN) begin : g_even
      assign par_calc = ^msg;
    end else if (PARITY == PAR_ODD) begin : g_odd
      assign par_calc = ~(^msg);
    end else begin : g_none
      assign par_calc = 1'b0;
    end
  endgenerate

  assign msg_ready = (state == IDLE) && EN;
  assign accept    = msg_ready && msg_valid;
  assign last_bit  = (bit_cnt == LAST_BIT);

  // The gap counter starts decrementing on the edge that leaves the frame,
  // so its zero flag marks the final stand-by cycle.
  assign to_gap = ((state == SEND) && last_bit && !HAS_PAR) || (state == PAR);
  assign sb_dec = EN && !sb_zero && (to_gap || (state == STANDBY));

  sb_down_counter #(
    .W (SB_W)
  ) u_sb_cnt (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (accept),
    .en       (sb_dec),
    .load_val (SB),
    .zero     (sb_zero)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_q      <= 1'b0;
      state_out  <= 1'b0;
      state_send <= 1'b0;
      busy       <= 1'b0;
    end else if (EN) begin
      state_send <= 1'b0;
      case (state)
        IDLE: begin
          state_out <= 1'b0;
          if (msg_valid) begin
            shreg      <= msg;
            par_q      <= par_calc;
            bit_cnt    <= '0;
            state_out  <= first_bit;
            state_send <= 1'b1;
            busy       <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (!last_bit) begin
            shreg     <= shreg_nxt;
            state_out <= nxt_bit;
            bit_cnt   <= bit_cnt + CNT_W'(1);
          end else if (HAS_PAR) begin
            state_out <= par_q;
            state     <= PAR;
          end else begin
            state_out <= 1'b0;
            if (sb_zero) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= STANDBY;
            end
          end
        end
        PAR: begin
          state_out <= 1'b0;
          if (sb_zero) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= STANDBY;
          end
        end
        STANDBY: begin
          state_out <= 1'b0;
          if (sb_zero) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state_out <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_serial_out.sv
// Directed bench for param_serial_out: four parameterisations, per-cycle expected
// line/handshake values queued at stimulus time and compared after each clock edge.
module tb_param_serial_out;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] msg;
  logic [3:0] sb;
  logic [3:0] vld;
  logic [3:0] rdy_w;
  logic [3:0] ss_w;
  logic [3:0] so_w;
  logic [3:0] bsy_w;

  typedef struct packed {
    logic so;
    logic ss;
    logic rdy;
    logic bsy;
  } exp_t;

  exp_t q[$];
  int   vec;
  int   miss;

  // u0: defaults; u1: LSB-first even; u2: LSB-first odd; u3: 8-bit MSB-first, no parity
  param_serial_out #(.MSG_W(4), .SB_W(4), .MSB_FIRST(1), .PARITY(0)) u0 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .msg(msg[3:0]), .msg_valid(vld[0]),
    .msg_ready(rdy_w[0]), .SB(sb), .state_send(ss_w[0]), .state_out(so_w[0]), .busy(bsy_w[0]));
  param_serial_out #(.MSG_W(4), .SB_W(4), .MSB_FIRST(0), .PARITY(1)) u1 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .msg(msg[3:0]), .msg_valid(vld[1]),
    .msg_ready(rdy_w[1]), .SB(sb), .state_send(ss_w[1]), .state_out(so_w[1]), .busy(bsy_w[1]));
  param_serial_out #(.MSG_W(4), .SB_W(4), .MSB_FIRST(0), .PARITY(2)) u2 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .msg(msg[3:0]), .msg_valid(vld[2]),
    .msg_ready(rdy_w[2]), .SB(sb), .state_send(ss_w[2]), .state_out(so_w[2]), .busy(bsy_w[2]));
  param_serial_out #(.MSG_W(8), .SB_W(4), .MSB_FIRST(1), .PARITY(0)) u3 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .msg(msg), .msg_valid(vld[3]),
    .msg_ready(rdy_w[3]), .SB(sb), .state_send(ss_w[3]), .state_out(so_w[3]), .busy(bsy_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic a, input logic e);
    vec++;
    assert (a === e) else begin
      miss++;
      $error("FAIL %s: observed %b expected %b", tag, a, e);
    end
  endtask

  task automatic push(input logic so, input logic ss, input logic rdy, input logic bsy);
    exp_t e;
    e = '{so: so, ss: ss, rdy: rdy, bsy: bsy};
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int s, input string tag);
    exp_t e;
    e = q.pop_front();
    cmp({tag, ".state_out"},  so_w[s],  e.so);
    cmp({tag, ".state_send"}, ss_w[s],  e.ss);
    cmp({tag, ".msg_ready"},  rdy_w[s], e.rdy);
    cmp({tag, ".busy"},       bsy_w[s], e.bsy);
  endtask

  task automatic drain(input int s, input string tag);
    while (q.size() > 0) begin
      tick();
      chk(s, tag);
    end
  endtask

  // Reference frame: data bits, optional parity, stand-by zeros, then one idle cycle.
  task automatic push_frame(input int s, input logic [7:0] w, input int sbn);
    int   width;
    int   msbf;
    int   pm;
    logic p;
    logic b;
    case (s)
      0:       begin width = 4; msbf = 1; pm = 0; end
      1:       begin width = 4; msbf = 0; pm = 1; end
      2:       begin width = 4; msbf = 0; pm = 2; end
      default: begin width = 8; msbf = 1; pm = 0; end
    endcase
    p = 1'b0;
    for (int i = 0; i < width; i++) p = p ^ w[i];
    for (int i = 0; i < width; i++) begin
      b = (msbf != 0) ? w[width-1-i] : w[i];
      push(b, (i == 0), 1'b0, 1'b1);
    end
    if (pm != 0) push((pm == 2) ? ~p : p, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < sbn; i++) push(1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic send(input int s, input logic [7:0] w, input logic [3:0] sb0,
                      input logic [3:0] sb1, input bit drop, input string tag);
    msg    = w;
    sb     = sb0;
    vld[s] = 1'b1;
    push_frame(s, w, int'(sb0));
    tick();
    sb = sb1;
    if (drop) vld[s] = 1'b0;
    chk(s, tag);
    drain(s, tag);
  endtask

  initial begin
    vec   = 0;
    miss  = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    msg   = '0;
    sb    = '0;
    vld   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    for (int s = 0; s < 4; s++) begin
      cmp("reset.state_out",  so_w[s],  1'b0);
      cmp("reset.state_send", ss_w[s],  1'b0);
      cmp("reset.busy",       bsy_w[s], 1'b0);
      cmp("reset.msg_ready",  rdy_w[s], 1'b1);
    end

    send(0, 8'h0A, 4'd3, 4'd3, 1'b1, "msb_1010_sb3");
    send(1, 8'h0B, 4'd1, 4'd1, 1'b1, "lsb_even_1011");
    send(2, 8'h0B, 4'd1, 4'd1, 1'b1, "lsb_odd_1011");
    send(3, 8'hA5, 4'd0, 4'd0, 1'b0, "b2b_a5");
    send(3, 8'h3C, 4'd0, 4'd0, 1'b1, "b2b_3c");
    send(0, 8'h06, 4'd3, 4'd7, 1'b1, "sb_change");

    // EN low for four edges after bit 1 of 1100; the line and busy must hold.
    msg = 8'h0C; sb = 4'd2; vld[0] = 1'b1;
    push(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    vld[0] = 1'b0;
    chk(0, "en_bit0");
    push(1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk(0, "en_bit1");
    en = 1'b0;
    repeat (4) begin
      push(1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      chk(0, "en_hold");
    end
    en = 1'b1;
    repeat (4) push(1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b1, 1'b0);
    drain(0, "en_resume");

    // EN low right after accept keeps the state_send pulse high while frozen.
    msg = 8'h06; sb = 4'd0; vld[0] = 1'b1;
    push(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    vld[0] = 1'b0;
    en = 1'b0;
    chk(0, "en_send_hold");
    repeat (2) begin
      push(1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      chk(0, "en_send_hold");
    end
    en = 1'b1;
    push(1'b1, 1'b0, 1'b0, 1'b1);
    push(1'b1, 1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b1, 1'b0);
    drain(0, "en_send_resume");

    en = 1'b0;
    #1;
    cmp("idle_en_low.msg_ready", rdy_w[0], 1'b0);
    en = 1'b1;
    #1;
    cmp("idle_en_high.msg_ready", rdy_w[0], 1'b1);

    // Asynchronous reset during bit 2 discards the frame.
    msg = 8'h0A; sb = 4'd3; vld[0] = 1'b1;
    push_frame(0, 8'h0A, 3);
    tick();
    vld[0] = 1'b0;
    chk(0, "rst_bit0");
    tick();
    chk(0, "rst_bit1");
    tick();
    chk(0, "rst_bit2");
    rst_n = 1'b0;
    q.delete();
    #1;
    cmp("rst_mid.state_out", so_w[0],  1'b0);
    cmp("rst_mid.busy",      bsy_w[0], 1'b0);
    cmp("rst_mid.state_send", ss_w[0], 1'b0);
    #1 rst_n = 1'b1;
    #1;
    cmp("rst_rel.msg_ready", rdy_w[0], 1'b1);
    cmp("rst_rel.busy",      bsy_w[0], 1'b0);
    cmp("rst_rel.state_out", so_w[0],  1'b0);
    send(0, 8'h03, 4'd1, 4'd1, 1'b1, "after_rst_0011");

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/param_serial_out.md
# param_serial_out

Parametrised successor to the fixed 4-bit serial transmitter. It serialises a `MSG_W`-bit word onto a single line, MSB- or LSB-first, with optional even/odd parity. Each frame is followed by a programmable stand-by gap, and a valid/ready handshake loads the next word. It sits between the message source logic and the physical serial output pin, and signals frame start on `state_send`.

## Interface
Parameters:
- `MSG_W`, default 4: message width in bits, ≥1.
- `SB_W`, default 4: width of the stand-by count input.
- `MSB_FIRST`, default 1: 1 = MSB transmitted first, 0 = LSB first.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `EN` in 1: global enable. When low, all internal and output registers hold.
- `msg` in `MSG_W`: word to transmit, sampled on accept.
- `msg_valid` in 1: source has a word.
- `msg_ready` out 1: block can accept a word.
- `SB` in `SB_W`: number of stand-by cycles after the frame, sampled on accept.
- `state_send` out 1: one-cycle pulse coincident with the first data bit.
- `state_out` out 1: serial line, registered, low when not driving a bit.
- `busy` out 1: high in SEND, PAR or STANDBY.

## Operation
- The FSM has four states: IDLE, SEND, PAR, STANDBY.
- Reset values: state IDLE, `state_out`=0, `state_send`=0, `busy`=0, shift register 0, counters 0. `msg_ready` = (state==IDLE) && `EN`, so it is 1 after reset when `EN`=1.
- Accept happens on a rising edge with `EN` && `msg_valid` && `msg_ready`. On accept:
  - `msg` is latched into the shift register and `SB` is latched into the stand-by counter.
  - Bit counter is set to 0, state goes to SEND.
  - `state_out` ← first bit (`msg[MSG_W-1]` if `MSB_FIRST`, else `msg[0]`), `state_send` ← 1.
- SEND: each enabled edge shifts and drives the next bit, with `state_send` ← 0.
  - After bit `MSG_W-1` has been driven for one cycle, go to PAR if `PARITY`≠0, else to STANDBY.
- PAR: drive one bit for one cycle.
  - Even parity: XOR of all `msg` bits.
  - Odd parity: inverted XOR.
  - Parity is computed from the latched word.
- STANDBY: `state_out`=0 for exactly the latched `SB` cycles, then IDLE. If latched `SB`=0, go directly from the last bit to IDLE.
- IDLE: `state_out`=0. `SB` or `msg` changes outside an accept edge have no effect.
- `EN`=0 at any point freezes state, counters and outputs at their current values, including a high `state_send`. Operation resumes exactly where it stopped.
- `RST_N` asserted mid-frame: all outputs go to their reset values immediately (asynchronously). The frame is discarded and not resumed.
- `msg_valid` held with `msg_ready`=0 is ignored. The source must hold `msg` until accepted.

## Timing
- Frame length L = `MSG_W` + (`PARITY`≠0 ? 1 : 0).
- Accept at edge k: bit i is on `state_out` during the cycle after edge k+i, for i = 0..L-1. `state_send` is high only during the cycle after edge k.
- Stand-by occupies the cycles after edges k+L .. k+L+SB-1. IDLE (`msg_ready`=1) starts after edge k+L+SB.
- With `msg_valid` held high and `EN`=1, frame period = L + SB + 1 cycles. The minimum one-cycle IDLE gap is mandatory.
- Bit counter width is $clog2(L). Stand-by counter is `SB_W` bits and counts down to 0. No wrap is possible because the load value is ≤ 2^`SB_W`-1.

## Structure
- Shared package `serial_pkg` holds:
  - state enum (IDLE, SEND, PAR, STANDBY);
  - parity mode constants (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2).
- One natural sub-module, `sb_down_counter`: load/enable/zero-flag down-counter of width `SB_W`, with the same `CLK`/`RST_N`. It is instantiated for the stand-by gap.
- Shift direction and the parity branch are resolved by generate on the parameters.

## Test plan
- Defaults, `SB`=3, `msg`=4'b1010, one accept: `state_out` 1,0,1,0,0,0,0. `state_send` high on the first cycle only. `msg_ready` low 7 cycles, high on the 8th.
- `MSB_FIRST`=0, `PARITY`=1, `SB`=1, `msg`=4'b1011: `state_out` 1,1,0,1, parity 1, then 0. Same with `PARITY`=2: parity bit 0.
- `MSG_W`=8, `SB`=0, `msg_valid` held, words 8'hA5 then 8'h3C: frames back-to-back with a period of 9 cycles and exactly one IDLE cycle between frames.
- `EN` low for 4 cycles after bit 1 of 4'b1100: `state_out` and `busy` hold, then bits 2..3 resume unchanged. Total busy time = 4 + 4 + SB.
- `RST_N` pulsed low at bit 2: `state_out`=0, `busy`=0, `msg_ready`=1 immediately after release. The next accepted word transmits cleanly.
- `SB` input changed from 3 to 7 mid-frame: stand-by lasts 3 cycles.
